fp_add_arbiter: RTL
===================

// Module: fp_add_arbiter
// PURPOSE
// Shares one floating-point adder core among N_REQ requesters. Accepts operand
// pairs over per-requester valid/ready, grants round-robin, sequences the core
// (operand load, start pulse, wait for valid, clear), then returns the sum with
// the requester id. Sits between client blocks and the adder datapath/controller.
// PARAMETERS
// N_REQ    4   number of requesters (2..8)
// WIDTH    32  operand/result width (IEEE-754 single)
// TIMEOUT  64  max WAIT cycles before abort (used only with FPADD_ARB_TIMEOUT_EN)
// PORTS
// clk          in   1              clock, all logic on posedge
// reset        in   1              reset, synchronous, active-high
// req_valid    in   N_REQ          per-requester operand pair valid
// req_a        in   N_REQ*WIDTH    operand A, requester i at [i*WIDTH +: WIDTH]
// req_b        in   N_REQ*WIDTH    operand B, same packing
// req_ready    out  N_REQ          one-hot accept; handshake = valid & ready
// fpa_a        out  WIDTH          operand A to adder core, held ISSUE..RESP
// fpa_b        out  WIDTH          operand B to adder core, held ISSUE..RESP
// fpa_start    out  1              one-cycle start pulse to core
// fpa_clear    out  1              returns core to idle (core reset input)
// fpa_valid    in   1              core result valid (level, held until clear)
// fpa_result   in   WIDTH          core sum
// rsp_valid    out  1              response valid
// rsp_id       out  $clog2(N_REQ)  requester id of response
// rsp_result   out  WIDTH          sum
// rsp_ready    in   1              response consumer ready
// busy         out  1              high in any state except IDLE
// timeout_err  out  1              qualifies rsp_valid: response is an abort
// BEHAVIOUR
// - States: IDLE, ISSUE, WAIT, RESP, CLEAR (registered FSM).
// - IDLE: if any req_valid, grant g = first valid index after last_ptr (wrapping);
//   req_ready[g]=1 combinationally this cycle only; latch a, b, id=g; -> ISSUE.
//   No request -> stay IDLE, req_ready=0.
// - ISSUE: fpa_start=1 for exactly one cycle; -> WAIT.
// - WAIT: fpa_valid=1 -> latch fpa_result into rsp_result; -> RESP.
// - RESP: rsp_valid=1, rsp_id/rsp_result stable until rsp_valid & rsp_ready;
//   then last_ptr<=id; -> CLEAR. rsp_ready low stalls indefinitely.
// - CLEAR: fpa_clear=1 one cycle; -> IDLE. fpa_clear also = reset.
// - Throughput: one operation per grant; no new grant before CLEAR completes.
//   Min latency: req handshake at cycle t, fpa_start at t+1, rsp_valid one
//   cycle after fpa_valid is first sampled high.
// - Round-robin: last_ptr resets to N_REQ-1, so requester 0 wins first; the
//   just-served requester has lowest priority next.
// - req_valid dropped without handshake: ignored, no state change.
// - fpa_valid high outside WAIT: ignored.
// - Reset (any state, incl. mid-WAIT): next cycle state=IDLE; all outputs 0
//   except fpa_clear=1 during reset; last_ptr=N_REQ-1; in-flight op discarded.
// CONFIGURATION
// - FPADD_ARB_TIMEOUT_EN defined: cycle counter runs in WAIT, cleared on entry;
//   if it reaches TIMEOUT without fpa_valid -> RESP with rsp_result=0 and
//   timeout_err=1 (held with rsp_valid until handshake), then CLEAR as usual.
// - Not defined: WAIT has no bound; timeout_err tied 0; no counter logic.
// TESTING
// - Reset, then req_valid=4'b0001, a=3F800000, b=40000000 -> start next cycle,
//   rsp_id=0, rsp_result=40400000 (1.0+2.0=3.0), fpa_clear pulse after handshake.
// - req_valid=4'b1111 held, 4 ops -> grant order 0,1,2,3; keep held -> 0 next.
// - After serving 2, req_valid=4'b0101 -> grant 0 (search starts at 3, wraps).
// - rsp_ready=0 for 10 cycles in RESP -> rsp_valid/id/result stable, no grant.
// - reset asserted in WAIT -> next cycle IDLE, busy=0, rsp_valid=0; next grant 0.
// - FPADD_ARB_TIMEOUT_EN, TIMEOUT=8, fpa_valid stuck 0 -> rsp_valid with
//   timeout_err=1, rsp_result=0 at WAIT entry+8; without macro -> stays in WAIT.

Source files
------------

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter
// Shares one floating-point adder core among N_REQ requesters. Operand pairs
// arrive over per-requester valid/ready and are granted round-robin. The core is
// sequenced through load, start pulse, wait for valid, then clear. The sum is
// returned together with the id of the requester that supplied the operands.
//
// Optional feature: define FPADD_ARB_TIMEOUT_EN to bound the wait for the core.
// If the core has not returned a result after TIMEOUT cycles in WAIT, the
// operation is aborted with rsp_result=0 and timeout_err=1.
//
// Ports
//   clk, reset        clock (posedge) and synchronous active-high reset
//   req_valid/ready   per-requester handshake; ready is one-hot, combinational
//   req_a, req_b      operands, requester i at [i*WIDTH +: WIDTH]
//   fpa_a, fpa_b      operands to the core, held from ISSUE through RESP
//   fpa_start         one-cycle start pulse to the core
//   fpa_clear         returns the core to idle; also asserted during reset
//   fpa_valid         core result valid (level), fpa_result = core sum
//   rsp_valid/ready   response handshake; rsp_id, rsp_result stable while valid
//   busy              high whenever the arbiter is not idle
//   timeout_err       qualifies rsp_valid: the response is an abort
module fp_add_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WIDTH-1:0]     req_a,
  input  logic [N_REQ*WIDTH-1:0]     req_b,
  output logic [N_REQ-1:0]           req_ready,
  output logic [WIDTH-1:0]           fpa_a,
  output logic [WIDTH-1:0]           fpa_b,
  output logic                       fpa_start,
  output logic                       fpa_clear,
  input  logic                       fpa_valid,
  input  logic [WIDTH-1:0]           fpa_result,
  output logic                       rsp_valid,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]           rsp_result,
  input  logic                       rsp_ready,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int unsigned IDW = $clog2(N_REQ);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [IDW-1:0]   r_last_ptr;
  logic [IDW-1:0]   r_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_fpa_start;
  logic             r_fpa_clear;
  logic             r_rsp_valid;
  logic             r_busy;

  logic [IDW-1:0]   w_grant_id;
  logic             w_grant_vld;
  logic             w_accept;
  logic             w_wait_expired;

  // Round-robin search: first valid index after r_last_ptr, wrapping.
  always_comb begin
    int unsigned v_idx;
    w_grant_id  = r_last_ptr;
    w_grant_vld = 1'b0;
    v_idx       = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      v_idx = (32'(r_last_ptr) + k) % N_REQ;
      if (!w_grant_vld && req_valid[IDW'(v_idx)]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = IDW'(v_idx);
      end
    end
  end

  // A grant is only offered from IDLE and never while reset is asserted.
  assign w_accept = (r_state == S_IDLE) && w_grant_vld && !reset;

  always_comb begin
    req_ready = '0;
    if (w_accept) begin
      req_ready[w_grant_id] = 1'b1;
    end
  end

`ifdef FPADD_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] r_wait_cnt;
  logic            r_timeout_err;

  // Counts cycles spent in WAIT; zero on every entry into WAIT.
  always_ff @(posedge clk) begin
    if (reset || (r_state != S_WAIT)) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + TO_W'(1);
    end
  end

  // Expiry is decided one cycle early so RESP begins exactly TIMEOUT cycles
  // after WAIT entry.
  assign w_wait_expired = (r_state == S_WAIT) && !fpa_valid &&
                          (r_wait_cnt == TO_W'(TIMEOUT - 1));

  // Abort flag rides along with the response until its handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timeout_err <= 1'b0;
    end else if (w_wait_expired) begin
      r_timeout_err <= 1'b1;
    end else if ((r_state == S_RESP) && rsp_ready) begin
      r_timeout_err <= 1'b0;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_wait_expired = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (fpa_valid || w_wait_expired) w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = S_CLEAR;
      S_CLEAR: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand/response datapath and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_ptr   <= IDW'(N_REQ - 1);
      r_id         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_rsp_result <= '0;
    end else begin
      if (w_accept) begin
        r_id <= w_grant_id;
        r_a  <= req_a[w_grant_id*WIDTH +: WIDTH];
        r_b  <= req_b[w_grant_id*WIDTH +: WIDTH];
      end
      if (r_state == S_WAIT) begin
        if (fpa_valid) begin
          r_rsp_result <= fpa_result;
        end else if (w_wait_expired) begin
          r_rsp_result <= '0;
        end
      end
      // The just-served requester drops to lowest priority.
      if ((r_state == S_RESP) && rsp_ready) begin
        r_last_ptr <= r_id;
      end
    end
  end

  // Control outputs registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fpa_start <= 1'b0;
      r_fpa_clear <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_fpa_start <= (w_state_nxt == S_ISSUE);
      r_fpa_clear <= (w_state_nxt == S_CLEAR);
      r_rsp_valid <= (w_state_nxt == S_RESP);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign fpa_a      = r_a;
  assign fpa_b      = r_b;
  assign fpa_start  = r_fpa_start;
  // The core is held cleared for as long as the arbiter is in reset.
  assign fpa_clear  = r_fpa_clear | reset;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_id;
  assign rsp_result = r_rsp_result;
  assign busy       = r_busy;

endmodule
